cache_mem_arbiter: RTL and testbench

//  Shares one physical-memory (L2) line port between the I-cache (fetch) and D-cache (stage 4 mem).
//  - One transaction in flight at a time; holds the grant until the memory responds.
//  - Routes the response back to the granted cache only.
//  - Sits between the two L1 cache controllers and the memory port at the top level.

---
 rtl/cache_mem_arbiter_if.sv | 76 +++++++
 rtl/cache_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Purpose: bundles the I-cache, D-cache and L2 memory line-port signals that
// meet at cache_mem_arbiter, so the arbiter and its environment share one
// definition of the bus.
//
// Parameters:
//   ADDR_W  byte-address width of all line ports (default 16)
//   LINE_W  cache-line width, 8 x 16-bit words (default 128)
//
// Signals:
//   I-cache : i_read, i_address        -> arbiter
//             i_rdata, i_resp          <- arbiter
//   D-cache : d_read, d_write,
//             d_address, d_wdata       -> arbiter
//             d_rdata, d_resp          <- arbiter
//   Memory  : mem_read, mem_write,
//             mem_address, mem_wdata   <- arbiter
//             mem_rdata, mem_resp      -> arbiter
//
// Modports:
//   master  the arbiter's view (drives memory strobes and cache responses)
//   slave   the surrounding view (caches and memory model)
//
// Handshake: a cache raises its request as a level and holds it until its
// one-cycle resp pulse; data returned on x_rdata is meaningful only in the
// cycle x_resp is high. The memory side sees level strobes held for the whole
// grant and answers with a one-cycle mem_resp, mem_rdata valid alongside it.
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);

  // I-cache port
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache port
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // L2 memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose: shares one L2 memory line port between the I-cache (fetch) and the
// D-cache (mem stage). One transaction is in flight at a time; the grant is
// held until the memory answers, and the answer is routed only to the cache
// that owns the grant.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          cache_mem_arbiter_if.master (cache and memory line ports)
//   arb_busy     out  1 while a grant is active (state != IDLE)
//   dbg_state_o  out  FSM state for debug/checkers (0 = IDLE, 1 = GNT_I,
//                     2 = GNT_D)
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, the D-cache wins simultaneous requests
//               (a stalled mem stage blocks retirement, so it drains first)
//   defined   : a last_gnt register (reset to I) makes ties go to the
//               requester that was not served last
//
// Handshake: requests are levels held until the matching one-cycle resp.
// A request seen in IDLE is granted at the next rising edge, so the memory
// strobe appears one cycle after the request. mem_resp returns the FSM to
// IDLE at the next edge, which guarantees one idle cycle between
// transactions and re-arbitrates any waiting request there.
//
// Memory-side outputs are combinational from the granted cache's inputs and
// are all zero outside a grant, so an asynchronous reset clears them without
// waiting for a clock edge.
// ---------------------------------------------------------------------------
module cache_mem_arbiter (
  input  logic                       clk,
  input  logic                       rst_n,
  cache_mem_arbiter_if.master        bus,
  output logic                       arb_busy,
  output logic [1:0]                 dbg_state_o
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // D-cache wants the port for either a fill or a write-back.
  logic d_req;
  assign d_req = bus.d_read | bus.d_write;

  // 1 when a simultaneous request should go to the D-cache.
  logic tie_to_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Which requester was granted most recently: 0 = I-cache, 1 = D-cache.
  logic last_gnt_q;
  logic last_gnt_d;

  // On a tie, the side that was not served last wins.
  assign tie_to_d = ~last_gnt_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req && bus.i_read) begin
          state_d = tie_to_d ? ST_GNT_D : ST_GNT_I;
        end else if (d_req) begin
          state_d = ST_GNT_D;
        end else if (bus.i_read) begin
          state_d = ST_GNT_I;
        end
      end
      // A request dropped while granted is a protocol error; the grant is
      // held regardless and only mem_resp releases it.
      ST_GNT_I,
      ST_GNT_D: begin
        if (bus.mem_resp) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  // last_gnt follows every entry into a grant state, tie or not.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_GNT_I) begin
        last_gnt_d = 1'b0;
      end else if (state_d == ST_GNT_D) begin
        last_gnt_d = 1'b1;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Memory-side muxing and response routing
  // -------------------------------------------------------------------------
  // d_read and d_write together is illegal but is forwarded untouched; the
  // memory model is expected to flag it.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        bus.mem_read    = bus.i_read;
        bus.mem_address = bus.i_address;
        bus.i_resp      = bus.mem_resp;
      end
      ST_GNT_D: begin
        bus.mem_read    = bus.d_read;
        bus.mem_write   = bus.d_write;
        bus.mem_address = bus.d_address;
        bus.mem_wdata   = bus.d_wdata;
        bus.d_resp      = bus.mem_resp;
      end
      default: begin
        // IDLE: strobes low, and a stray mem_resp is not passed on.
      end
    endcase
  end

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  assign arb_busy    = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. Inputs are driven and outputs
// sampled on the falling edge; combinational responses to mem_resp are
// sampled 1 time unit after it is raised, still far from the rising edge.
//
// The reference model is transaction level: for each scenario it works out
// the order in which the caches must be served from the arbitration rule
// (D wins ties, or alternation when ARB_ROUND_ROBIN_EN is defined), pushes
// that order into exp_q, and then expects one memory transaction per entry,
// with a one-cycle request-to-strobe latency and one idle cycle in between.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk;
  logic       rst_n;
  logic       arb_busy;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .arb_busy    (arb_busy),
    .dbg_state_o (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // -------------------------------------------------------------------------
  int   n_vec;
  int   n_miss;
  int   n_i_grants;
  int   n_d_grants;
  logic last_model;   // requester served most recently: 0 = I, 1 = D

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Winner of a simultaneous request: 1 = D-cache, 0 = I-cache.
  function automatic logic tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return ~last_model;
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_grant(input logic g);
    if (g) n_d_grants++;
    else   n_i_grants++;
    last_model = g;
  endtask

  task automatic clear_inputs();
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy",   arb_busy, 0);
    check("rst_state",  dbg_state, 0);
    check("rst_mrd",    bus.mem_read, 0);
    check("rst_mwr",    bus.mem_write, 0);
    check("rst_maddr",  bus.mem_address, 0);
    check("rst_mwdata", bus.mem_wdata, 0);
    check("rst_iresp",  bus.i_resp, 0);
    check("rst_dresp",  bus.d_resp, 0);
    rst_n      = 1'b1;
    last_model = 1'b0;
    @(negedge clk);
  endtask

  // One arbitration scenario: optional I read, optional D read/write, an
  // optional withdrawal of the losing request, and a fixed memory latency.
  task automatic run_case(input bit want_i, input bit want_d, input bit d_wr,
                          input bit withdraw, input int lat,
                          input logic [ADDR_W-1:0] ia,
                          input logic [ADDR_W-1:0] da,
                          input logic [LINE_W-1:0] wd,
                          input logic [LINE_W-1:0] rd);
    logic [0:0] exp_q[$];
    logic       g;
    logic       loser;
    bit         drop_loser;
    logic [LINE_W-1:0] rdata;

    @(negedge clk);
    bus.i_read    = want_i;
    bus.i_address = ia;
    bus.d_read    = want_d & ~d_wr;
    bus.d_write   = want_d & d_wr;
    bus.d_address = da;
    bus.d_wdata   = wd;
    #1;
    check("pre_grant_busy", arb_busy, 0);
    check("pre_grant_mrd",  bus.mem_read | bus.mem_write, 0);

    exp_q.delete();
    loser = 1'b0;
    if (want_i && want_d) begin
      g = tie_winner();
      exp_q.push_back(g);
      loser = ~g;
      if (!withdraw) exp_q.push_back(loser);
    end else if (want_i) begin
      exp_q.push_back(1'b0);
    end else if (want_d) begin
      exp_q.push_back(1'b1);
    end
    drop_loser = withdraw && want_i && want_d;

    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      note_grant(g);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        check("gnt_busy",  arb_busy, 1);
        check("gnt_mrd",   bus.mem_read,    g ? {127'd0, ~d_wr} : 128'd1);
        check("gnt_mwr",   bus.mem_write,   g ? {127'd0,  d_wr} : 128'd0);
        check("gnt_maddr", bus.mem_address, g ? da : ia);
        check("gnt_wdata", bus.mem_wdata,   g ? wd : 128'd0);
        check("wait_iresp", bus.i_resp, 0);
        check("wait_dresp", bus.d_resp, 0);
        if (drop_loser) begin
          if (loser) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
          end else begin
            bus.i_read = 1'b0;
          end
          drop_loser = 1'b0;
        end
        if (c == lat - 1) begin
          rdata = (rd != '0) ? rd : {$urandom, $urandom, $urandom, $urandom};
          bus.mem_rdata = rdata;
          bus.mem_resp  = 1'b1;
          #1;
          check("resp_i", bus.i_resp, {127'd0, ~g});
          check("resp_d", bus.d_resp, {127'd0,  g});
          check("rdata",  g ? bus.d_rdata : bus.i_rdata, rdata);
        end
      end
      // mem_resp is still high here but the arbiter is already idle.
      @(negedge clk);
      check("post_busy",  arb_busy, 0);
      check("post_resp",  {bus.i_resp, bus.d_resp}, 0);
      bus.mem_resp = 1'b0;
      if (g) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.i_read = 1'b0;
      end
    end

    if (withdraw && want_i && want_d) begin
      @(negedge clk);
      check("withdrawn_busy", arb_busy, 0);
      check("withdrawn_strb", bus.mem_read | bus.mem_write, 0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    n_vec      = 0;
    n_miss     = 0;
    n_i_grants = 0;
    n_d_grants = 0;
    last_model = 1'b0;
    apply_reset();

    // I-cache read alone, 3-cycle memory.
    run_case(1, 0, 0, 0, 3, 16'h0040, 16'h0000, '0, {16{8'hA5}});
    // D-cache write-back.
    run_case(0, 1, 1, 0, 2, 16'h0000, 16'h1230,
             128'h0123456789ABCDEF0123456789ABCDEF, '0);
    // Simultaneous I and D reads.
    run_case(1, 1, 0, 0, 2, 16'h0100, 16'h0200, '0, '0);
    // Same tie, repeated after a reset so the sequence starts from last_gnt = I.
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_case(1, 1, 0, 0, 1, 16'h0300 + 16'(k), 16'h0400 + 16'(k), '0, '0);
    end

    // Reset two cycles into a D grant aborts it immediately.
    @(negedge clk);
    bus.d_read    = 1'b1;
    bus.d_address = 16'h0ABC;
    repeat (2) @(negedge clk);
    check("abort_busy_pre", arb_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_mrd",   bus.mem_read, 0);
    check("abort_mwr",   bus.mem_write, 0);
    check("abort_dresp", bus.d_resp, 0);
    check("abort_busy",  arb_busy, 0);
    clear_inputs();
    last_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", arb_busy, 0);

    // Stray mem_resp while idle.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {4{32'hDEADBEEF}};
    #1;
    check("stray_iresp", bus.i_resp, 0);
    check("stray_dresp", bus.d_resp, 0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("stray_busy", arb_busy, 0);

    // I-cache drops its request mid-grant: grant held until mem_resp.
    bus.i_read    = 1'b1;
    bus.i_address = 16'h0770;
    @(negedge clk);
    check("drop_busy0", arb_busy, 1);
    note_grant(1'b0);
    bus.i_read = 1'b0;
    @(negedge clk);
    check("drop_busy1", arb_busy, 1);
    check("drop_mrd",   bus.mem_read, 0);
    bus.mem_resp = 1'b1;
    #1;
    check("drop_iresp", bus.i_resp, 1);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("drop_idle", arb_busy, 0);

    // Illegal d_read + d_write forwarded unmasked.
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 16'h0880;
    @(negedge clk);
    note_grant(1'b1);
    check("both_mrd", bus.mem_read, 1);
    check("both_mwr", bus.mem_write, 1);
    bus.mem_resp = 1'b1;
    #1;
    check("both_dresp", bus.d_resp, 1);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    clear_inputs();
    check("both_idle", arb_busy, 0);

    // Randomized scenarios.
    for (int k = 0; k < 40; k++) begin
      bit wi, wdq, wr, wdr;
      wi  = 1'($urandom_range(0, 1));
      wdq = 1'($urandom_range(0, 1));
      if (!wi && !wdq) wdq = 1'b1;
      wr  = 1'($urandom_range(0, 1));
      wdr = ($urandom_range(0, 3) == 0);
      run_case(wi, wdq, wr, wdr, $urandom_range(1, 5),
               16'($urandom), 16'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, '0);
    end

    $display("grants served: I=%0d D=%0d", n_i_grants, n_d_grants);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
